// File: rtl/bus_arbit_2m.sv
// Two-master bus arbiter with a slave-side multiplexer for the 16-bit-address / 64-bit-data bus.
// Define ARB_FAIRNESS_EN to build the hold-limit counter that forces handover to a waiting master.
module bus_arbit_2m #(
  parameter int unsigned MaxHold = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_req_i,
  input  logic        m1_req_i,
  input  logic        m0_wr_i,
  input  logic        m1_wr_i,
  input  logic [15:0] m0_addr_i,
  input  logic [15:0] m1_addr_i,
  input  logic [63:0] m0_dout_i,
  input  logic [63:0] m1_dout_i,
  output logic        m0_grant_o,
  output logic        m1_grant_o,
  output logic        s_wr_o,
  output logic [15:0] s_addr_o,
  output logic [63:0] s_din_o,
  output logic        arb_busy_o
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StGnt0 = 2'b01,
    StGnt1 = 2'b10
  } state_e;

  state_e state_q, state_d;
  logic   m0_grant_q, m1_grant_q;
  logic   hold_expired;

`ifdef ARB_FAIRNESS_EN
  localparam int unsigned CntW = (MaxHold > 1) ? $clog2(MaxHold) : 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(MaxHold - 1);

  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;

  assign hold_expired = (hold_cnt_q == HoldLast);

  // Clears on every state change, counts owned cycles, saturates at the last allowed cycle.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_d != state_q) begin
      hold_cnt_d = '0;
    end else if ((state_q == StGnt0 || state_q == StGnt1) && !hold_expired) begin
      hold_cnt_d = hold_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  // Owner keeps the bus while requesting, unless its hold window ran out with the other waiting.
  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle: begin
        if (m0_req_i) begin
          state_d = StGnt0;
        end else if (m1_req_i) begin
          state_d = StGnt1;
        end else begin
          state_d = StIdle;
        end
      end
      StGnt0: begin
        if (m0_req_i && !(hold_expired && m1_req_i)) begin
          state_d = StGnt0;
        end else if (m1_req_i) begin
          state_d = StGnt1;
        end else begin
          state_d = StIdle;
        end
      end
      StGnt1: begin
        if (m1_req_i && !(hold_expired && m0_req_i)) begin
          state_d = StGnt1;
        end else if (m0_req_i) begin
          state_d = StGnt0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Grants are registered alongside the state so they mirror the state register exactly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      m0_grant_q <= 1'b0;
      m1_grant_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m0_grant_q <= (state_d == StGnt0);
      m1_grant_q <= (state_d == StGnt1);
    end
  end

  assign m0_grant_o = m0_grant_q;
  assign m1_grant_o = m1_grant_q;
  assign arb_busy_o = m0_grant_q | m1_grant_q;

  always_comb begin
    s_wr_o   = 1'b0;
    s_addr_o = 16'h0;
    s_din_o  = 64'h0;
    unique case (state_q)
      StGnt0: begin
        s_wr_o   = m0_wr_i;
        s_addr_o = m0_addr_i;
        s_din_o  = m0_dout_i;
      end
      StGnt1: begin
        s_wr_o   = m1_wr_i;
        s_addr_o = m1_addr_i;
        s_din_o  = m1_dout_i;
      end
      default: begin
        s_wr_o   = 1'b0;
        s_addr_o = 16'h0;
        s_din_o  = 64'h0;
      end
    endcase
  end

endmodule
